serial_tx: RTL and testbench

- Parallel-in, serial-out transmitter: the sending end of the single-bit serial link whose receive side is a shift chain of dff stages.
- Accepts a WIDTH-bit word through a valid/ready handshake.
- Drives the word onto sout MSB-first, one bit per clock, with a frame qualifier and an optional even-parity bit.
- Pulses done when the frame ends.

---
 rtl/serial_tx.sv | 114 +++++++++++
 tb/tb_serial_tx.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/serial_tx.sv
// serial_tx: parallel-in, serial-out transmitter.
// Accepts a WIDTH-bit word through a valid/ready handshake and shifts it out
// MSB-first, one bit per clock. When PARITY=1, an even-parity bit follows the
// data bits. The frame output qualifies each bit, and done pulses for one
// cycle as the frame ends.
//
// Ports:
//   clk        - system clock, rising edge
//   reset      - asynchronous, active-high reset
//   load_valid - load_data holds a word to send
//   load_ready - transmitter is idle and can accept a word
//   load_data  - word to transmit (WIDTH bits)
//   sout       - serial data bit (registered)
//   frame      - high while sout carries a data or parity bit (registered)
//   done       - one-cycle pulse in the cycle frame falls (registered)
module serial_tx #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned PARITY = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  output logic             sout,
  output logic             frame,
  output logic             done
);

  localparam int unsigned FLEN = WIDTH + PARITY;
  localparam int unsigned CW   = $clog2(FLEN + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q,   cnt_d;
  logic             par_q,   par_d;
  logic             sout_q,  sout_d;
  logic             frame_q, frame_d;
  logic             done_q,  done_d;
  logic             emit_bit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      par_q   <= 1'b0;
      sout_q  <= 1'b0;
      frame_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      par_q   <= par_d;
      sout_q  <= sout_d;
      frame_q <= frame_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    cnt_d    = cnt_q;
    par_d    = par_q;
    sout_d   = sout_q;
    frame_d  = frame_q;
    done_d   = 1'b0;
    emit_bit = shreg_q[WIDTH-1];

    unique case (state_q)
      IDLE: begin
        sout_d  = 1'b0;
        frame_d = 1'b0;
        if (load_valid) begin
          // The MSB goes out on the accept edge itself, so the shift register
          // keeps only the remaining bits and the count starts at FLEN-1.
          sout_d  = load_data[WIDTH-1];
          frame_d = 1'b1;
          shreg_d = load_data << 1;
          par_d   = load_data[WIDTH-1];
          cnt_d   = CW'(FLEN - 1);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_q != '0) begin
          // Last slot of a parity frame carries the accumulated parity.
          if (PARITY != 0 && cnt_q == CW'(1)) emit_bit = par_q;
          sout_d  = emit_bit;
          frame_d = 1'b1;
          shreg_d = shreg_q << 1;
          par_d   = par_q ^ emit_bit;
          cnt_d   = cnt_q - CW'(1);
        end else begin
          sout_d  = 1'b0;
          frame_d = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign load_ready = (state_q == IDLE);
  assign sout       = sout_q;
  assign frame      = frame_q;
  assign done       = done_q;

endmodule

// File: tb/tb_serial_tx.sv
// Directed, table-driven bench for serial_tx. Three instances cover
// WIDTH=8/PARITY=0, WIDTH=8/PARITY=1 and WIDTH=2/PARITY=0. Inputs are driven
// and outputs sampled on the falling clock edge.
module tb_serial_tx;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] lv = '0;
  logic [7:0] d0 = '0, d1 = '0;
  logic [1:0] d2 = '0;
  logic [2:0] rdy, so, fr, dn;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  serial_tx #(.WIDTH(8), .PARITY(0)) u0 (
    .clk(clk), .reset(reset), .load_valid(lv[0]), .load_ready(rdy[0]),
    .load_data(d0), .sout(so[0]), .frame(fr[0]), .done(dn[0]));

  serial_tx #(.WIDTH(8), .PARITY(1)) u1 (
    .clk(clk), .reset(reset), .load_valid(lv[1]), .load_ready(rdy[1]),
    .load_data(d1), .sout(so[1]), .frame(fr[1]), .done(dn[1]));

  serial_tx #(.WIDTH(2), .PARITY(0)) u2 (
    .clk(clk), .reset(reset), .load_valid(lv[2]), .load_ready(rdy[2]),
    .load_data(d2), .sout(so[2]), .frame(fr[2]), .done(dn[2]));

  typedef struct {
    int         sel;   // which instance
    logic [7:0] data;
    int         flen;  // expected frame length
    logic [8:0] bits;  // expected sout sequence, first bit at [flen-1]
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input logic act, input logic exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_idle(input int s, input string tag);
    chk({tag, " ready"}, rdy[s], 1'b1);
    chk({tag, " sout"},  so[s],  1'b0);
    chk({tag, " frame"}, fr[s],  1'b0);
    chk({tag, " done"},  dn[s],  1'b0);
  endtask

  task automatic drive(input int s, input logic v, input logic [7:0] d);
    lv[s] = v;
    case (s)
      0: d0 = d;
      1: d1 = d;
      default: d2 = d[1:0];
    endcase
  endtask

  // Send one word (caller is at a falling edge) and check the whole frame.
  task automatic send(input int s, input logic [7:0] d, input int flen,
                      input logic [8:0] bits, input string tag);
    drive(s, 1'b1, d);
    chk({tag, " ready pre"}, rdy[s], 1'b1);
    for (int i = 0; i < flen; i++) begin
      @(negedge clk);
      if (i == 0) drive(s, 1'b0, ~d);  // later data changes must not matter
      chk($sformatf("%s bit%0d sout", tag, i), so[s], bits[flen-1-i]);
      chk($sformatf("%s bit%0d frame", tag, i), fr[s], 1'b1);
      chk($sformatf("%s bit%0d ready", tag, i), rdy[s], 1'b0);
      chk($sformatf("%s bit%0d done", tag, i), dn[s], 1'b0);
    end
    @(negedge clk);
    chk({tag, " end frame"}, fr[s],  1'b0);
    chk({tag, " end done"},  dn[s],  1'b1);
    chk({tag, " end ready"}, rdy[s], 1'b1);
    chk({tag, " end sout"},  so[s],  1'b0);
    @(negedge clk);
    check_idle(s, {tag, " after"});
  endtask

  initial begin
    tbl[0] = '{sel: 0, data: 8'hA5, flen: 8, bits: 9'b0_1010_0101};
    tbl[1] = '{sel: 0, data: 8'h01, flen: 8, bits: 9'b0_0000_0001};
    tbl[2] = '{sel: 1, data: 8'h07, flen: 9, bits: 9'b0000_0111_1};
    tbl[3] = '{sel: 1, data: 8'h03, flen: 9, bits: 9'b0000_0011_0};
    tbl[4] = '{sel: 1, data: 8'hFF, flen: 9, bits: 9'b1111_1111_0};
    tbl[5] = '{sel: 1, data: 8'h80, flen: 9, bits: 9'b1000_0000_1};
    tbl[6] = '{sel: 2, data: 8'h02, flen: 2, bits: 9'b0_0000_0010};
    tbl[7] = '{sel: 2, data: 8'h01, flen: 2, bits: 9'b0_0000_0001};

    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Idle after reset release.
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      for (int s = 0; s < 3; s++) check_idle(s, $sformatf("idle%0d u%0d", c, s));
    end

    for (int i = 0; i < 8; i++)
      send(tbl[i].sel, tbl[i].data, tbl[i].flen, tbl[i].bits, $sformatf("vec%0d", i));

    // Back-to-back with load_valid held high: 0x81 then 0xFF.
    drive(0, 1'b1, 8'h81);
    for (int i = 0; i < 8; i++) begin
      logic [7:0] w;
      w = 8'h81;
      @(negedge clk);
      if (i == 0) d0 = 8'h00;
      if (i == 5) d0 = 8'hFF;
      chk($sformatf("b2b A bit%0d sout", i), so[0], w[7-i]);
      chk($sformatf("b2b A bit%0d frame", i), fr[0], 1'b1);
    end
    @(negedge clk);
    chk("b2b gap frame", fr[0], 1'b0);
    chk("b2b gap done",  dn[0], 1'b1);
    chk("b2b gap ready", rdy[0], 1'b1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk($sformatf("b2b B bit%0d sout", i), so[0], 1'b1);
      chk($sformatf("b2b B bit%0d frame", i), fr[0], 1'b1);
      chk($sformatf("b2b B bit%0d done", i), dn[0], 1'b0);
    end
    @(negedge clk);
    drive(0, 1'b0, 8'h00);
    chk("b2b end frame", fr[0], 1'b0);
    chk("b2b end done",  dn[0], 1'b1);
    @(negedge clk);
    check_idle(0, "b2b after");

    // Asynchronous reset during bit 4 of 0xF0.
    drive(0, 1'b1, 8'hF0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) drive(0, 1'b0, 8'h00);
      chk($sformatf("rst bit%0d sout", i), so[0], 1'b1);
      chk($sformatf("rst bit%0d frame", i), fr[0], 1'b1);
    end
    @(negedge clk);
    chk("rst bit4 frame", fr[0], 1'b1);
    #2 reset = 1'b1;
    #1;
    chk("rst async frame", fr[0], 1'b0);
    chk("rst async sout",  so[0], 1'b0);
    chk("rst async ready", rdy[0], 1'b1);
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_idle(0, $sformatf("rst idle%0d", c));
    end
    send(0, 8'h3C, 8, 9'b0_0011_1100, "post-rst 3C");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
